// File: rtl/display_bcd_seq.sv
// ---------------------------------------------------------------------------
// display_bcd_seq
//   Output stage for the register-file toOUT bus. A new signed 32-bit value
//   is captured, converted to BCD by a 14-step sequential double-dabble
//   engine, and only then written to the four 7-segment digit registers.
//   The digit outputs are therefore never seen in a partial state.
//
// Ports
//   clk      : system (divided) clock, rising edge
//   reset    : asynchronous, active-high
//   entrada  : signed two's-complement value to display
//   saida4   : leftmost digit (thousands or sign), [0]=a .. [6]=g
//   saida3   : hundreds
//   saida2   : tens
//   saida1   : ones
//   ocupado  : high while a conversion is in progress
// ---------------------------------------------------------------------------
module display_bcd_seq #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_ZEROS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] entrada,
    output logic [0:6]  saida4,
    output logic [0:6]  saida3,
    output logic [0:6]  saida2,
    output logic [0:6]  saida1,
    output logic        ocupado
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Digit codes beyond 0..9 used by the segment lookup.
    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    function automatic logic [0:6] segOf(input logic [3:0] code);
        logic [0:6] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'd10:   s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? s : ~s;
    endfunction

    // Upper three digits at reset: blank, or '0' when blanking is disabled.
    localparam logic [3:0] RESET_UPPER = BLANK_ZEROS ? CODE_BLANK : 4'd0;

    logic [1:0]  state;
    logic [31:0] captured;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [3:0]  iter;
    logic        neg;
    logic        ovf;

    // Capture-side range analysis of the incoming value.
    logic        inNeg;
    logic        inRange;
    logic [31:0] inMag;

    always_comb begin
        inNeg   = entrada[31];
        inRange = inNeg ? ($signed(entrada) >= -32'sd999)
                        : ($signed(entrada) <= 32'sd9999);
        inMag   = inNeg ? (~entrada + 32'd1) : entrada;
    end

    // Double-dabble correction applied before each shift.
    logic [15:0] bcdAdj;

    always_comb begin
        bcdAdj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Final digit selection. A negative in-range magnitude is at most 999, so
    // its thousands nibble is zero and the same blanking chain serves both signs.
    logic [3:0] code4, code3, code2, code1;
    logic       lit3, lit2, lit1;

    always_comb begin
        lit3 = !BLANK_ZEROS || (bcd[15:12] != 4'd0);
        lit2 = lit3 || (bcd[11:8] != 4'd0);
        lit1 = lit2 || (bcd[7:4]  != 4'd0);
        if (ovf) begin
            code4 = CODE_DASH;
            code3 = CODE_DASH;
            code2 = CODE_DASH;
            code1 = CODE_DASH;
        end else begin
            code4 = neg  ? CODE_DASH : (lit3 ? bcd[15:12] : CODE_BLANK);
            code3 = lit2 ? bcd[11:8] : CODE_BLANK;
            code2 = lit1 ? bcd[7:4]  : CODE_BLANK;
            code1 = bcd[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            captured <= '0;
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            ocupado  <= 1'b0;
            saida4   <= segOf(RESET_UPPER);
            saida3   <= segOf(RESET_UPPER);
            saida2   <= segOf(RESET_UPPER);
            saida1   <= segOf(4'd0);
        end else begin
            case (state)
                IDLE: begin
                    if (entrada != captured) begin
                        captured <= entrada;
                        neg      <= inNeg && inRange;
                        ovf      <= !inRange;
                        // Out-of-range values still run the engine (on zero)
                        // so every update has the same latency.
                        bin      <= inRange ? inMag[13:0] : 14'd0;
                        bcd      <= '0;
                        iter     <= '0;
                        ocupado  <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    {bcd, bin} <= {bcdAdj[14:0], bin, 1'b0};
                    iter       <= iter + 4'd1;
                    if (iter == 4'd13)
                        state <= DONE;
                end
                DONE: begin
                    saida4  <= segOf(code4);
                    saida3  <= segOf(code3);
                    saida2  <= segOf(code2);
                    saida1  <= segOf(code1);
                    ocupado <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
